// File: rtl/ring_divider_if.sv
// Tile pin bundle for ring_divider: enable, dedicated inputs and the
// bidirectional pin group. The design drives the outputs; the environment drives the inputs.
interface ring_divider_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/ring_divider.sv
// Programmable divider: prescaler ticks toggle a 50% clock and step a 4-bit Johnson ring.
// Optional macro RING_DIVIDER_CLR_EN adds a synchronous clear on uio_in[0].
module ring_divider #(
    parameter int EDGE_CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    ring_divider_if.slave  bus
);

    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            d_q, d_d;
    logic                  div_q, div_d;
    logic [3:0]            ring_q, ring_d;
    logic                  tick_q, tick_d;
    logic [EDGE_CNT_W-1:0] edge_q, edge_d;
    logic                  run_q, run_d;
    logic [7:0]            edge_ext;

`ifdef RING_DIVIDER_CLR_EN
    logic       clr;
    logic [6:0] unused_uio;
    assign clr        = bus.uio_in[0];
    assign unused_uio = bus.uio_in[7:1];
`else
    logic [7:0] unused_uio;
    assign unused_uio = bus.uio_in;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        d_d    = d_q;
        div_d  = div_q;
        ring_d = ring_q;
        tick_d = 1'b0;
        edge_d = edge_q;
        run_d  = bus.ena;
        if (bus.ena) begin
            // D is sampled only at a tick, so a new divide value never cuts an interval short.
            if (cnt_q == d_q) begin
                cnt_d  = 8'd0;
                d_d    = bus.ui_in;
                div_d  = ~div_q;
                ring_d = {ring_q[2:0], ~ring_q[3]};
                tick_d = 1'b1;
                if (!div_q) begin
                    edge_d = edge_q + EDGE_CNT_W'(1);
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
`ifdef RING_DIVIDER_CLR_EN
        if (clr) begin
            cnt_d  = 8'd0;
            d_d    = 8'd0;
            div_d  = 1'b0;
            ring_d = 4'd0;
            tick_d = 1'b0;
            edge_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 8'd0;
            d_q    <= 8'd0;
            div_q  <= 1'b0;
            ring_q <= 4'd0;
            tick_q <= 1'b0;
            edge_q <= '0;
            run_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            d_q    <= d_d;
            div_q  <= div_d;
            ring_q <= ring_d;
            tick_q <= tick_d;
            edge_q <= edge_d;
            run_q  <= run_d;
        end
    end

    always_comb begin
        edge_ext                   = 8'd0;
        edge_ext[EDGE_CNT_W-1:0]   = edge_q;
    end

    assign bus.uo_out  = {run_q, ring_q[3], ring_q, tick_q, div_q};
    assign bus.uio_out = edge_ext;
    assign bus.uio_oe  = 8'hFF;

endmodule

// File: tb/tb_ring_divider.sv
// Scoreboard bench for ring_divider: the driver pushes expected {uo_out,uio_out}
// per clock edge (or async reset), an independent monitor pops and compares.
module tb_ring_divider;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ring_divider_if bus ();

    ring_divider #(.EDGE_CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scoreboard
    logic [15:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: phase index into the Johnson sequence, integer edge count
    localparam logic [3:0] RING_TBL [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    int   m_cnt, m_d, m_phase, m_edge;
    logic m_div, m_tick, m_run;

    task automatic model_reset();
        m_cnt = 0; m_d = 0; m_phase = 0; m_edge = 0;
        m_div = 1'b0; m_tick = 1'b0; m_run = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic [7:0] ui, input logic clr);
        m_run = en;
        if (clr) begin
            m_cnt = 0; m_d = 0; m_phase = 0; m_edge = 0;
            m_div = 1'b0; m_tick = 1'b0;
        end else if (!en) begin
            m_tick = 1'b0;
        end else if (m_cnt == m_d) begin
            m_cnt   = 0;
            m_d     = int'(ui);
            if (!m_div) m_edge = (m_edge + 1) % 256;
            m_div   = ~m_div;
            m_phase = (m_phase + 1) % 8;
            m_tick  = 1'b1;
        end else begin
            m_cnt  = m_cnt + 1;
            m_tick = 1'b0;
        end
    endtask

    function automatic logic [15:0] model_out();
        logic [3:0] r;
        logic [7:0] e;
        r = RING_TBL[m_phase];
        e = m_edge[7:0];
        return {m_run, r[3], r, m_tick, m_div, e};
    endfunction

    // Driver tasks: inputs change on the falling edge, expectation pushed for the next rising edge
    task automatic step(input logic en, input logic [7:0] ui, input string nm, input logic clr = 1'b0);
        @(negedge clk);
        bus.ena    = en;
        bus.ui_in  = ui;
        bus.uio_in = {7'b0, clr};
        model_edge(en, ui, clr);
        exp_q.push_back(model_out());
        name_q.push_back(nm);
    endtask

    task automatic step_exp(input logic en, input logic [7:0] ui, input logic [15:0] exp, input string nm);
        @(negedge clk);
        bus.ena    = en;
        bus.ui_in  = ui;
        bus.uio_in = 8'h00;
        model_edge(en, ui, 1'b0);
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // Monitor
    initial begin
        logic [15:0] got, e;
        string       n;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() > 0) begin
                got = {bus.uo_out, bus.uio_out};
                e   = exp_q.pop_front();
                n   = name_q.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s: got uo_out=%h uio_out=%h, expected uo_out=%h uio_out=%h",
                             n, got[15:8], got[7:0], e[15:8], e[7:0]);
                end
                checks++;
                if (bus.uio_oe !== 8'hFF) begin
                    errors++;
                    $display("FAIL uio_oe(%s): got %h, expected ff", n, bus.uio_oe);
                end
            end
        end
    end

    // Stimulus
    initial begin
        bus.ena    = 1'b0;
        bus.ui_in  = 8'd0;
        bus.uio_in = 8'd0;
        model_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        exp_q.push_back(16'h0000);
        name_q.push_back("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // ui_in=3: hand-computed first two tick intervals
        step_exp(1'b1, 8'd3, 16'h8701, "first_tick");
        step_exp(1'b1, 8'd3, 16'h8501, "cnt1");
        step_exp(1'b1, 8'd3, 16'h8501, "cnt2");
        step_exp(1'b1, 8'd3, 16'h8501, "cnt3");
        step_exp(1'b1, 8'd3, 16'h8E01, "second_tick");
        step_exp(1'b1, 8'd3, 16'h8C01, "low_cnt1");
        step_exp(1'b1, 8'd3, 16'h8C01, "low_cnt2");
        step_exp(1'b1, 8'd3, 16'h8C01, "low_cnt3");
        step_exp(1'b1, 8'd3, 16'h9F02, "third_tick");
        repeat (20) step(1'b1, 8'd3, "div3");

        // D=0: toggle every clock
        repeat (16) step(1'b1, 8'd0, "div0");

        // D changed mid-interval
        repeat (2) step(1'b1, 8'd3, "pre_change");
        repeat (30) step(1'b1, 8'd9, "div9");

        // Freeze and resume
        repeat (20) step(1'b0, 8'd9, "hold");
        repeat (15) step(1'b1, 8'd9, "resume");

        // Edge counter wrap
        repeat (600) step(1'b1, 8'd0, "wrap");

        // Asynchronous reset mid-interval
        repeat (3) step(1'b1, 8'd5, "pre_rst");
        @(negedge clk);
        bus.ena = 1'b0;
        #2;
        exp_q.push_back(16'h0000);
        name_q.push_back("async_rst");
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step_exp(1'b1, 8'd2, 16'h8701, "post_rst_tick");
        repeat (6) step(1'b1, 8'd2, "post_rst");

`ifdef RING_DIVIDER_CLR_EN
        repeat (5) step(1'b1, 8'd4, "pre_clr");
        step(1'b1, 8'd4, "sync_clr", 1'b1);
        step_exp(1'b1, 8'd4, 16'h8701, "post_clr_tick");
        repeat (4) step(1'b1, 8'd4, "post_clr");
`endif

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ring_divider.md
Name: ring_divider

Overview:
- Programmable clock divider with a 4-bit Johnson (twisted-ring) phase generator, in the TinyTapeout user-tile wrapper style.
- An 8-bit prescaler on `ui_in` sets the tick rate.
- Each tick toggles a 50%-duty divided clock and advances the ring, producing four phase taps and a divide-by-8-ticks output.
- A rising-edge counter of the divided clock drives the bidirectional pins as outputs.

Parameters:
- EDGE_CNT_W, default 8, width of the divided-clock rising-edge counter. Legal range 1..8. `uio_out` bits above EDGE_CNT_W-1 are 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  tile enable; 0 freezes all state.
- ui_in  in  8  divide value D (unsigned).
- uio_in  in  8  unused, except bit 0 when RING_DIVIDER_CLR_EN is defined.
- uo_out  out  8  [0] div_clk, [1] tick, [5:2] ring[3:0], [6] ring[3] (slow clock), [7] running.
- uio_out  out  8  edge counter, zero-extended from EDGE_CNT_W.
- uio_oe  out  8  constant 8'hFF.

Behaviour:
- Reset (async, rst=1) clears all state to 0:
  - cnt (8b), d_reg (8b), div_clk, ring (4b), tick_q, edge_cnt, run_q.
  - Consequence: uo_out=0, uio_out=0, uio_oe=FF.
- run_q is a register of ena, so uo_out[7] follows ena with one cycle of latency.
- Enabled clock edge (ena=1), tick condition is cnt == d_reg:
  - On tick: cnt<=0; d_reg<=ui_in; div_clk<=~div_clk; ring<={ring[2:0],~ring[3]}; tick_q<=1.
  - On a tick where div_clk goes 0->1: edge_cnt<=edge_cnt+1, wrapping modulo 2^EDGE_CNT_W.
  - Otherwise: cnt<=cnt+1; tick_q<=0.
- First enabled edge after reset is always a tick, because cnt=d_reg=0. That edge loads D and sets div_clk=1, ring=0001, edge_cnt=1.
- Tick spacing is D+1 clocks:
  - div_clk period = 2(D+1) clocks, 50% duty.
  - ring[3] period = 8(D+1) clocks.
  - D=0 gives div_clk = clk/2 and tick_q held at 1.
  - D=255 gives tick every 256 clocks; cnt never exceeds 255.
- Ring sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then repeats. Only these 8 states are reachable.
- ui_in changes take effect only at the next tick, when D is reloaded; the current interval is never truncated or glitched.
- ena=0 holds cnt, d_reg, div_clk, ring and edge_cnt; tick_q<=0. Resuming continues counting where it stopped.
- Reset asserted mid-operation: all outputs return to 0 immediately (asynchronous), uio_oe stays FF.
- All outputs are registered or constant; no combinational path from inputs to outputs.

Optional Feature:
- Macro: RING_DIVIDER_CLR_EN.
- When defined, uio_in[0]=1 is a synchronous clear on the next clock edge, regardless of ena:
  - Clears cnt, d_reg, div_clk, ring, tick_q, edge_cnt.
  - run_q still follows ena.
  - Clear takes priority over tick.
  - After release, the first enabled edge is a tick, as after reset.
- When undefined, uio_in is fully ignored and no clear logic is present.

Test Plan:
- Reset, then ena=1, ui_in=3 -> first edge: uo_out[0]=1, ring=0001, uio_out=1. After that, div_clk toggles every 4 clocks (period 8), tick pulses 1 clock every 4, uio_out increments every 8 clocks.
- ui_in=0 -> div_clk toggles every clock, uo_out[1] constantly 1, ring completes 8 states in 8 clocks, uo_out[6] period 8.
- ui_in=3, then change to 9 mid-interval -> current interval still 4 clocks; following intervals are 10 clocks.
- ena=0 for 20 clocks mid-interval -> uo_out[0], ring and uio_out frozen, uo_out[1]=0, uo_out[7]=0 one cycle after ena falls. On re-enable, the remaining interval completes with the correct count.
- ui_in=0 for 600 clocks -> uio_out wraps 255->0; uio_oe=FF throughout.
- Reset asserted asynchronously mid-interval -> uo_out=0 and uio_out=0 without a clock edge. With RING_DIVIDER_CLR_EN, uio_in[0]=1 for one clock gives the same cleared state on that clock edge.
